alto_alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational Alto ALU.
- Executes the same 4-bit ALU function set in one cycle.
- Adds iterative unsigned multiply (WIDTH x WIDTH -> 2*WIDTH) and unsigned divide (2*WIDTH / WIDTH), both driven by a start/ready/done handshake.
- Sits beside the emulator datapath and serves the MUL/DIV microcode paths.

---
 rtl/alto_alu_seq.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alto_alu_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alto_alu_seq.sv
// alto_alu_seq: registered Alto ALU with iterative unsigned multiply and divide.
//
// The 4-bit ALU function set completes one cycle after acceptance. MUL (WIDTH x WIDTH ->
// 2*WIDTH) and DIV (2*WIDTH / WIDTH) run one shift-add or restoring-subtract step per cycle
// and complete WIDTH+1 cycles after acceptance. A request is accepted when
// start_i & ready_o.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      request strobe
//   cmd_i        0=ALU, 1=MUL, 2=DIV, 3=ALU
//   aluf_i       ALU function code (ALU only)
//   a_i          BUS operand / multiplicand / dividend low word
//   ahi_i        dividend high word (DIV only)
//   b_i          T operand / multiplier / divisor
//   skip_i       skip bit for BUS+SKIP
//   ready_o      request can be accepted this cycle
//   done_o       one-cycle completion pulse
//   result_o     ALU result / product low / quotient
//   result_hi_o  product high / remainder / 0 for ALU
//   carry_o      ALU carry-out, 0 for MUL/DIV
//   zero_o       result_o==0 (ALU/DIV), whole product==0 (MUL)
//   ovf_o        divide overflow (ahi_i >= b_i)
module alto_alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       cmd_i,
  input  logic [3:0]       aluf_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] ahi_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             skip_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             ovf_o
);

  // Alto ALU function encodings.
  localparam logic [3:0] AlufBus          = 4'd0;
  localparam logic [3:0] AlufT            = 4'd1;
  localparam logic [3:0] AlufBusOrT       = 4'd2;
  localparam logic [3:0] AlufBusAndT      = 4'd3;
  localparam logic [3:0] AlufBusXorT      = 4'd4;
  localparam logic [3:0] AlufBusPlus1     = 4'd5;
  localparam logic [3:0] AlufBusMinus1    = 4'd6;
  localparam logic [3:0] AlufBusPlusT     = 4'd7;
  localparam logic [3:0] AlufBusMinusT    = 4'd8;
  localparam logic [3:0] AlufBusMinusTM1  = 4'd9;
  localparam logic [3:0] AlufBusPlusTP1   = 4'd10;
  localparam logic [3:0] AlufBusPlusSkip  = 4'd11;
  localparam logic [3:0] AlufBusAndTLoad  = 4'd12;
  localparam logic [3:0] AlufBusAndNotT   = 4'd13;

  localparam logic [1:0] CmdMul = 2'd1;
  localparam logic [1:0] CmdDiv = 2'd2;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Working registers: MUL keeps {partial product high, multiplier/product low};
  // DIV keeps {partial remainder, dividend/quotient}. opnd holds multiplicand or divisor.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
  logic             done_q, done_d, carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d;

  // ALU datapath; arithmetic in WIDTH+1 bits so bit WIDTH is the carry.
  logic [WIDTH:0]   a_x, b_x, alu_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  always_comb begin
    a_x       = {1'b0, a_i};
    b_x       = {1'b0, b_i};
    alu_sum   = '0;
    alu_res   = a_i;
    alu_carry = 1'b0;
    case (aluf_i)
      AlufBus:         alu_res = a_i;
      AlufT:           alu_res = b_i;
      AlufBusOrT:      alu_res = a_i | b_i;
      AlufBusAndT,
      AlufBusAndTLoad: alu_res = a_i & b_i;
      AlufBusXorT:     alu_res = a_i ^ b_i;
      AlufBusAndNotT:  alu_res = a_i & ~b_i;
      AlufBusPlus1,
      AlufBusMinus1,
      AlufBusPlusT,
      AlufBusMinusT,
      AlufBusMinusTM1,
      AlufBusPlusTP1,
      AlufBusPlusSkip: begin
        case (aluf_i)
          AlufBusPlus1:    alu_sum = a_x + (WIDTH+1)'(1);
          AlufBusMinus1:   alu_sum = a_x + {1'b0, {WIDTH{1'b1}}};
          AlufBusPlusT:    alu_sum = a_x + b_x;
          // Subtraction as a + ~b + 1: carry set means no borrow.
          AlufBusMinusT:   alu_sum = a_x + {1'b0, ~b_i} + (WIDTH+1)'(1);
          AlufBusMinusTM1: alu_sum = a_x + {1'b0, ~b_i};
          AlufBusPlusTP1:  alu_sum = a_x + b_x + (WIDTH+1)'(1);
          default:         alu_sum = a_x + {{WIDTH{1'b0}}, skip_i};
        endcase
        alu_res   = alu_sum[WIDTH-1:0];
        alu_carry = alu_sum[WIDTH];
      end
      default: alu_res = a_i;
    endcase
  end

  // One shift-add step, multiplier consumed LSB-first from lo_q.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

  // One restoring-divide step; the shifted remainder needs WIDTH+1 bits.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};

    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_n  = {lo_q[WIDTH-2:0], div_ge};
  end

  logic cnt_last;
  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));
  assign ready_o  = (state_q == StIdle);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          case (cmd_i)
            CmdMul: begin
              state_d = StMul;
              cnt_d   = '0;
              hi_d    = '0;
              lo_d    = b_i;
              opnd_d  = a_i;
            end
            CmdDiv: begin
              if (ahi_i >= b_i) begin
                // Quotient would not fit (covers divide by zero): complete at once.
                done_d   = 1'b1;
                res_d    = '1;
                res_hi_d = ahi_i;
                carry_d  = 1'b0;
                zero_d   = 1'b0;
                ovf_d    = 1'b1;
              end else begin
                state_d = StDiv;
                cnt_d   = '0;
                hi_d    = ahi_i;
                lo_d    = a_i;
                opnd_d  = b_i;
              end
            end
            default: begin
              done_d   = 1'b1;
              res_d    = alu_res;
              res_hi_d = '0;
              carry_d  = alu_carry;
              zero_d   = (alu_res == '0);
              ovf_d    = 1'b0;
            end
          endcase
        end
      end
      StMul: begin
        hi_d  = mul_hi_n;
        lo_d  = mul_lo_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_last) begin
          state_d  = StIdle;
          cnt_d    = '0;
          done_d   = 1'b1;
          res_d    = mul_lo_n;
          res_hi_d = mul_hi_n;
          carry_d  = 1'b0;
          zero_d   = ({mul_hi_n, mul_lo_n} == '0);
          ovf_d    = 1'b0;
        end
      end
      StDiv: begin
        hi_d  = div_hi_n;
        lo_d  = div_lo_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_last) begin
          state_d  = StIdle;
          cnt_d    = '0;
          done_d   = 1'b1;
          res_d    = div_lo_n;
          res_hi_d = div_hi_n;
          carry_d  = 1'b0;
          zero_d   = (div_lo_n == '0);
          ovf_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign done_o      = done_q;
  assign result_o    = res_q;
  assign result_hi_o = res_hi_q;
  assign carry_o     = carry_q;
  assign zero_o      = zero_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_alto_alu_seq.sv
// Testbench for alto_alu_seq at WIDTH=16: an operation-level reference model plus a
// per-cycle compare process, with literal expectations on the directed scenarios.
module tb_alto_alu_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    cmd = 2'd0;
  logic [3:0]    aluf = 4'd0;
  logic [W-1:0]  a = '0, ahi = '0, b = '0;
  logic          skip = 1'b0;
  logic          ready, done, carry, zero, ovf;
  logic [W-1:0]  result, result_hi;

  int tests = 0;
  int fails = 0;

  alto_alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cmd_i(cmd), .aluf_i(aluf),
    .a_i(a), .ahi_i(ahi), .b_i(b), .skip_i(skip),
    .ready_o(ready), .done_o(done), .result_o(result), .result_hi_o(result_hi),
    .carry_o(carry), .zero_o(zero), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         o;
  } out_t;

  function automatic out_t model_op(input logic [1:0] c, input logic [3:0] f,
                                    input logic [W-1:0] av, input logic [W-1:0] hv,
                                    input logic [W-1:0] bv, input logic sk);
    out_t        e;
    int unsigned x, y, r;
    logic [31:0] p, n;
    bit          cy;
    e = '0;
    x = av;
    y = bv;
    if (c == 2'd1) begin
      p = x * y;
      e.res = p[15:0];
      e.hi = p[31:16];
      e.z = (p == 0);
    end else if (c == 2'd2) begin
      if (hv >= bv) begin
        e.res = 16'hFFFF;
        e.hi = hv;
        e.o = 1'b1;
      end else begin
        n = {hv, av};
        p = n / y;
        e.res = p[15:0];
        p = n % y;
        e.hi = p[15:0];
        e.z = (e.res == 0);
      end
    end else begin
      cy = 1'b0;
      case (f)
        4'd1:  r = y;
        4'd2:  r = x | y;
        4'd3:  r = x & y;
        4'd4:  r = x ^ y;
        4'd5:  begin r = x + 1;     cy = (x == 65535); end
        4'd6:  begin r = x - 1;     cy = (x != 0); end
        4'd7:  begin r = x + y;     cy = (x + y > 65535); end
        4'd8:  begin r = x - y;     cy = (x >= y); end
        4'd9:  begin r = x - y - 1; cy = (x > y); end
        4'd10: begin r = x + y + 1; cy = (x + y + 1 > 65535); end
        4'd11: begin r = x + sk;    cy = (x + sk > 65535); end
        4'd12: r = x & y;
        4'd13: r = x & ~y;
        default: r = x;
      endcase
      e.res = r[15:0];
      e.c = cy;
      e.z = (e.res == 0);
    end
    return e;
  endfunction

  function automatic int model_lat(input logic [1:0] c, input logic [W-1:0] hv,
                                   input logic [W-1:0] bv);
    if (c == 2'd1) return W;
    if (c == 2'd2 && hv < bv) return W;
    return 0;
  endfunction

  int   m_left = 0;   // edges still to go before a pending completion shows
  logic m_done = 1'b0;
  out_t m_out = '0, m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_out  <= m_pend;
        end
      end else if (start) begin
        if (model_lat(cmd, ahi, b) == 0) begin
          m_done <= 1'b1;
          m_out  <= model_op(cmd, aluf, a, ahi, b, skip);
        end else begin
          m_left <= model_lat(cmd, ahi, b);
          m_pend <= model_op(cmd, aluf, a, ahi, b, skip);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", ready, m_left == 0);
      chk("done", done, m_done);
      chk("result", result, m_out.res);
      chk("result_hi", result_hi, m_out.hi);
      chk("carry", carry, m_out.c);
      chk("zero", zero, m_out.z);
      chk("ovf", ovf, m_out.o);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic go(input logic [1:0] c, input logic [3:0] f, input logic [W-1:0] av,
                    input logic [W-1:0] hv, input logic [W-1:0] bv, input logic sk);
    @(negedge clk);
    start = 1'b1; cmd = c; aluf = f; a = av; ahi = hv; b = bv; skip = sk;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done_o, bounded; n = negedges stepped, busy = cycles seen with ready_o low.
  task automatic wait_done(output int n, output int busy);
    n = 0;
    busy = 0;
    while (!done && n < 60) begin
      if (!ready) busy++;
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  typedef struct {
    logic [1:0]   c;
    logic [W-1:0] av, hv, bv;
  } vec_t;

  initial begin
    int   n, busy, dones;
    vec_t vecs[6];
    logic [W-1:0] opa[3];
    logic [W-1:0] opb[3];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1); chk("rst_done", done, 0); chk("rst_result", result, 0);
    chk("rst_hi", result_hi, 0); chk("rst_flags", {carry, zero, ovf}, 0);
    #1 rst = 1'b0;

    // ALU BUS+T wraps to zero with carry
    go(2'd0, 4'd7, 16'hFFFF, 16'h0, 16'h0001, 1'b0);
    lit("alu_add_done", done, m_done, 1);
    lit("alu_add_res", result, m_out.res, 16'h0000);
    lit("alu_add_carry", carry, m_out.c, 1);
    lit("alu_add_zero", zero, m_out.z, 1);
    lit("alu_add_hi", result_hi, m_out.hi, 0);

    go(2'd0, 4'd8, 16'h0005, 16'h0, 16'h0007, 1'b0);
    lit("alu_sub_res", result, m_out.res, 16'hFFFE);
    lit("alu_sub_carry", carry, m_out.c, 0);

    // Every function code, issued back to back (reserved cmd 3 behaves as ALU)
    opa[0] = 16'h1234; opb[0] = 16'h00FF;
    opa[1] = 16'h0000; opb[1] = 16'hFFFF;
    opa[2] = 16'hFFFF; opb[2] = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      for (int f = 0; f < 16; f++) begin
        @(negedge clk);
        start = 1'b1; cmd = (f[0] && k == 2) ? 2'd3 : 2'd0; aluf = f[3:0];
        a = opa[k]; b = opb[k]; skip = f[1];
      end
    end
    @(negedge clk);
    start = 1'b0;

    // MUL: operands change after acceptance and must not matter
    go(2'd1, 4'd0, 16'hFFFF, 16'h0, 16'hFFFF, 1'b0);
    a = 16'h1357; b = 16'h2468;
    wait_done(n, busy);
    chk("mul_latency", n + 1, 17);
    chk("mul_busy", busy, 16);
    lit("mul_hi", result_hi, m_out.hi, 16'hFFFE);
    lit("mul_lo", result, m_out.res, 16'h0001);
    lit("mul_zero", zero, m_out.z, 0);

    // DIV 0x10000 / 3
    go(2'd2, 4'd0, 16'h0000, 16'h0001, 16'h0003, 1'b0);
    wait_done(n, busy);
    chk("div_latency", n + 1, 17);
    lit("div_q", result, m_out.res, 16'h5555);
    lit("div_r", result_hi, m_out.hi, 16'h0001);
    lit("div_ovf", ovf, m_out.o, 0);

    // DIV by zero overflows immediately; a following ALU op clears ovf
    go(2'd2, 4'd0, 16'h0000, 16'h1234, 16'h0000, 1'b0);
    lit("ovf_done", done, m_done, 1);
    lit("ovf_flag", ovf, m_out.o, 1);
    lit("ovf_res", result, m_out.res, 16'hFFFF);
    lit("ovf_hi", result_hi, m_out.hi, 16'h1234);
    go(2'd0, 4'd0, 16'h0005, 16'h0, 16'h0, 1'b0);
    lit("ovf_clear", ovf, m_out.o, 0);

    // Boundary MUL/DIV cases, checked by the model
    vecs[0] = '{2'd1, 16'h0000, 16'h0, 16'h1234};
    vecs[1] = '{2'd1, 16'h8000, 16'h0, 16'h0002};
    vecs[2] = '{2'd2, 16'hABCD, 16'h1233, 16'h1234};
    vecs[3] = '{2'd2, 16'hABCD, 16'h0005, 16'h0005};
    vecs[4] = '{2'd2, 16'h0000, 16'h0000, 16'h0007};
    vecs[5] = '{2'd2, 16'hFFFF, 16'hFFFE, 16'hFFFF};
    foreach (vecs[i]) begin
      go(vecs[i].c, 4'd0, vecs[i].av, vecs[i].hv, vecs[i].bv, 1'b0);
      wait_done(n, busy);
    end

    // start held through a MUL with another cmd: ignored until the done cycle
    @(negedge clk);
    start = 1'b1; cmd = 2'd1; a = 16'h0003; b = 16'h0005;
    @(negedge clk);
    cmd = 2'd0; aluf = 4'd4; a = 16'h00FF; b = 16'h0F0F;
    wait_done(n, busy);
    chk("held_latency", n + 1, 17);
    lit("held_mul", result, m_out.res, 16'h000F);
    @(negedge clk);
    start = 1'b0;
    lit("held_alu_done", done, m_done, 1);
    lit("held_alu_res", result, m_out.res, 16'h0FF0);
    @(negedge clk);
    lit("held_single", done, m_done, 0);

    // Reset mid-MUL aborts at once with no later completion
    go(2'd1, 4'd0, 16'h1234, 16'h0, 16'h5678, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", ready, 1); chk("abort_done", done, 0);
    chk("abort_result", result, 0); chk("abort_hi", result_hi, 0);
    chk("abort_flags", {carry, zero, ovf}, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    go(2'd0, 4'd4, 16'h00FF, 16'h0, 16'h0F0F, 1'b0);
    lit("post_rst_xor", result, m_out.res, 16'h0FF0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
